// File: rtl/alu_rr_sequencer.sv
// alu_rr_sequencer
//   Shares one WIDTH-bit add/subtract datapath between two requesters.
//   A round-robin arbiter picks one requester while idle. A three-state FSM
//   (IDLE -> EXEC -> RESP) captures the operands, computes the result and
//   holds it until the consumer takes it. Only one operation is in flight.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req{0,1}_valid / _ready    request handshake (ready only while IDLE)
//   req{0,1}_a / _b / _sub     operands and opcode (1 = A-B, 0 = A+B)
//   rsp_valid / rsp_ready      response handshake
//   rsp_id                     requester that owns the response
//   rsp_result / rsp_carry     WIDTH-bit result and carry-out (sub: 1 = no borrow)
//   rsp_equal                  captured A == captured B
//   busy                       FSM is not in IDLE
//   ops_done                   count of completed response handshakes (wraps)

module alu_rr_sequencer #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_equal,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic             op_id;

  logic             grant0;
  logic             grant1;
  logic             take;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_full;

  // Round-robin grant, only offered while idle. On a conflict the requester
  // that did not win last time gets ready. Gating with rst_n keeps both
  // readies low for the whole time reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && (state == IDLE)) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign take       = grant0 | grant1;
  assign busy       = (state != IDLE);

  // Subtraction is A + ~B + 1. The carry-in comes from the opcode, so carry-out
  // set means "no borrow" for a subtract.
  assign b_eff    = op_sub ? ~op_b : op_b;
  assign sum_full = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sub};

  // Sequencer. IDLE captures the granted request, so later operand changes
  // cannot disturb the operation. EXEC registers the datapath outputs. RESP
  // holds them until the consumer accepts. last_grant resets to 1 so that
  // requester 0 wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_sub     <= 1'b0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_equal  <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            op_a       <= grant1 ? req1_a   : req0_a;
            op_b       <= grant1 ? req1_b   : req0_b;
            op_sub     <= grant1 ? req1_sub : req0_sub;
            op_id      <= grant1;
            last_grant <= grant1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= sum_full[WIDTH-1:0];
          rsp_carry  <= sum_full[WIDTH];
          rsp_equal  <= (op_a == op_b);
          rsp_id     <= op_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb_alu_rr_sequencer
//   Directed bench for alu_rr_sequencer. Inputs change on the falling edge and
//   outputs are sampled 1 time unit later, away from the rising active edge.
//   Expected values are worked out by hand from the operation definitions.

module tb_alu_rr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req0_valid;
  logic       req0_ready;
  logic [5:0] req0_a;
  logic [5:0] req0_b;
  logic       req0_sub;
  logic       req1_valid;
  logic       req1_ready;
  logic [5:0] req1_a;
  logic [5:0] req1_b;
  logic       req1_sub;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [5:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_equal;
  logic       busy;
  logic [7:0] ops_done;

  int         total;
  int         bad;
  logic [7:0] exp_ops;

  alu_rr_sequencer #(
    .WIDTH(6),
    .CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_equal  (rsp_equal),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and on a mismatch count the failure and report.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One complete operation from a single requester, with rsp_ready raised as
  // soon as the response appears. Operands are scrambled right after the
  // handshake to show the in-flight operation no longer depends on them.
  task automatic applyStimulus(input logic id, input logic [5:0] a,
                               input logic [5:0] b, input logic sub,
                               input logic [5:0] exp_res, input logic exp_c,
                               input logic exp_e);
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end
    #1 checkOutput("grant", 32'({req1_ready, req0_ready}), id ? 32'd2 : 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = ~req0_a; req0_b = req0_b + 6'd1; req0_sub = ~req0_sub;
    req1_a = ~req1_a; req1_b = req1_b + 6'd1; req1_sub = ~req1_sub;
    #1;
    checkOutput("exec_busy", 32'(busy), 32'd1);
    checkOutput("exec_ready", 32'({req1_ready, req0_ready}), 32'd0);
    checkOutput("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("rsp_id", 32'(rsp_id), 32'(id));
    checkOutput("rsp_result", 32'(rsp_result), 32'(exp_res));
    checkOutput("rsp_carry", 32'(rsp_carry), 32'(exp_c));
    checkOutput("rsp_equal", 32'(rsp_equal), 32'(exp_e));
    rsp_ready = 1'b1;
    exp_ops = exp_ops + 8'd1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checkOutput("done_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("done_busy", 32'(busy), 32'd0);
    checkOutput("ops_done", 32'(ops_done), 32'(exp_ops));
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    exp_ops    = 8'd0;
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_a = 6'd0; req0_b = 6'd0; req0_sub = 1'b0;
    req1_a = 6'd0; req1_b = 6'd0; req1_sub = 1'b0;
    rsp_ready  = 1'b0;

    // Reset state, with both requesters valid: no ready while rst_n is low.
    #12;
    checkOutput("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_ops_done", 32'(ops_done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_result", 32'(rsp_result), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic.
    applyStimulus(1'b0, 6'b001100, 6'b110011, 1'b0, 6'b111111, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'b101010, 6'b010101, 1'b1, 6'b010101, 1'b1, 1'b0);
    applyStimulus(1'b0, 6'b000000, 6'b000001, 1'b1, 6'b111111, 1'b0, 1'b0);
    applyStimulus(1'b1, 6'b110000, 6'b110000, 1'b1, 6'b000000, 1'b1, 1'b1);
    applyStimulus(1'b0, 6'b110000, 6'b110000, 1'b0, 6'b100000, 1'b1, 1'b1);

    // Backpressure: requester 1 computes 5+9=14, then the response is held
    // for 5 cycles while requester 0 waits with valid high.
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 6'd5; req1_b = 6'd9; req1_sub = 1'b0;
    #1 checkOutput("bp_grant", 32'({req1_ready, req0_ready}), 32'd2);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 6'd1; req0_b = 6'd1; req0_sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_result", 32'(rsp_result), 32'd14);
      checkOutput("bp_id", 32'(rsp_id), 32'd1);
      checkOutput("bp_busy", 32'(busy), 32'd1);
      checkOutput("bp_ready", 32'({req1_ready, req0_ready}), 32'd0);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    rsp_ready  = 1'b1;
    exp_ops    = exp_ops + 8'd1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checkOutput("bp_release_busy", 32'(busy), 32'd0);
    checkOutput("bp_release_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_ops_done", 32'(ops_done), 32'(exp_ops));

    // Arbitration: both requesters always valid, consumer always ready.
    // Last winner was requester 1, so grants go 0,1,0,1 with one response
    // every 3 cycles. Req0 computes 1+2=3, req1 computes 10-3=7.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 6'd1;  req0_b = 6'd2; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 6'd10; req1_b = 6'd3; req1_sub = 1'b1;
    rsp_ready  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if ((c % 3) == 0) begin
        checkOutput("arb_grant", 32'({req1_ready, req0_ready}),
                    (((c / 3) % 2) == 1) ? 32'd2 : 32'd1);
        checkOutput("arb_idle_valid", 32'(rsp_valid), 32'd0);
      end else if ((c % 3) == 1) begin
        checkOutput("arb_exec_ready", 32'({req1_ready, req0_ready}), 32'd0);
      end else begin
        checkOutput("arb_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("arb_rsp_id", 32'(rsp_id), 32'((c / 3) % 2));
        checkOutput("arb_result", 32'(rsp_result),
                    (((c / 3) % 2) == 1) ? 32'd7 : 32'd3);
        checkOutput("arb_resp_ready", 32'({req1_ready, req0_ready}), 32'd0);
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_ops    = exp_ops + 8'd4;
    #1;
    checkOutput("arb_busy", 32'(busy), 32'd0);
    checkOutput("arb_ops_done", 32'(ops_done), 32'(exp_ops));
    rsp_ready = 1'b0;

    // Reset in the middle of EXEC.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 6'd7; req0_b = 6'd7; req0_sub = 1'b0;
    #1 checkOutput("rexec_grant", 32'({req1_ready, req0_ready}), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1 checkOutput("rexec_busy_before", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rexec_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rexec_ops_done", 32'(ops_done), 32'd0);
    checkOutput("rexec_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of RESP. Requester 0 wins here, which would make
    // requester 1 next in line unless reset restores the initial priority.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 6'd20; req0_b = 6'd3; req0_sub = 1'b0;
    #1 checkOutput("rresp_grant", 32'({req1_ready, req0_ready}), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    #1 checkOutput("rresp_valid_before", 32'(rsp_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rresp_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rresp_ops_done", 32'(ops_done), 32'd0);
    checkOutput("rresp_busy", 32'(busy), 32'd0);
    checkOutput("rresp_result", 32'(rsp_result), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ops = 8'd0;

    // After reset both valid: requester 0 first. 2+3=5.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 6'd2; req0_b = 6'd3; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 6'd9; req1_b = 6'd9; req1_sub = 1'b0;
    #1 checkOutput("post_rst_grant", 32'({req1_ready, req0_ready}), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("post_rst_id", 32'(rsp_id), 32'd0);
    checkOutput("post_rst_result", 32'(rsp_result), 32'd5);
    rsp_ready = 1'b1;
    exp_ops   = exp_ops + 8'd1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 checkOutput("post_rst_ops_done", 32'(ops_done), 32'(exp_ops));

    // Counter wrap: one op is done, 255 more at one per 3 cycles bring the
    // count to 256, which reads back as 0.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 6'd1; req0_b = 6'd1; req0_sub = 1'b0;
    rsp_ready  = 1'b1;
    for (int i = 1; i <= 765; i++) begin
      @(negedge clk);
      if (i == 762) begin
        #1 checkOutput("wrap_255", 32'(ops_done), 32'd255);
      end
    end
    req0_valid = 1'b0;
    rsp_ready  = 1'b0;
    #1;
    checkOutput("wrap_0", 32'(ops_done), 32'd0);
    checkOutput("wrap_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
